local_inject_ni: RTL and testbench

LOCAL_INJECT_NI -- requirements
Module: local_inject_ni

---
 rtl/local_inject_ni_if.sv | 25 ++
 rtl/local_inject_ni.sv | 81 ++++++++
 tb/tb_local_inject_ni.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/local_inject_ni_if.sv
// Core-to-router local injection bundle: packet request from the core,
// flit/valid to the router local port and the router's credit return.
interface local_inject_ni_if #(
  parameter int unsigned PAYLOAD_FLITS = 3
);
  logic                       req_valid_i;
  logic                       req_ready_o;
  logic [15:0]                req_dest_i;
  logic [16*PAYLOAD_FLITS-1:0] req_payload_i;
  logic [15:0]                noc_data_o;
  logic                       noc_valid_o;
  logic                       noc_credit_i;
  logic                       busy_o;
  logic                       credit_err_o;

  modport master (
    output req_valid_i, req_dest_i, req_payload_i, noc_credit_i,
    input  req_ready_o, noc_data_o, noc_valid_o, busy_o, credit_err_o
  );

  modport slave (
    input  req_valid_i, req_dest_i, req_payload_i, noc_credit_i,
    output req_ready_o, noc_data_o, noc_valid_o, busy_o, credit_err_o
  );
endinterface

// File: rtl/local_inject_ni.sv
// Local injection network interface: serialises a header plus PAYLOAD_FLITS
// payload flits into the router local port under credit-based flow control.
module local_inject_ni #(
  parameter int unsigned PAYLOAD_FLITS = 3,
  parameter int unsigned BUF_DEPTH     = 8
) (
  input logic               clk,
  input logic               reset,
  local_inject_ni_if.slave  bus
);
  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned IW = (PAYLOAD_FLITS > 1) ? $clog2(PAYLOAD_FLITS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, HEAD = 2'd1, BODY = 2'd2} state_t;

  state_t                        state, state_next;
  logic [CW-1:0]                 credit_cnt;
  logic [IW-1:0]                 idx;
  logic [15:0]                   dest_q;
  logic [PAYLOAD_FLITS-1:0][15:0] pay_q;
  logic [15:0]                   flit;
  logic                          send, accept, last;
  logic                          noc_valid_q;
  logic [15:0]                   noc_data_q;
  logic                          err_q;

  assign bus.req_ready_o  = reset && (state == IDLE);
  assign bus.busy_o       = reset && (state != IDLE);
  assign bus.noc_valid_o  = noc_valid_q;
  assign bus.noc_data_o   = noc_data_q;
  assign bus.credit_err_o = err_q;

  always_comb begin
    send       = (state != IDLE) && (credit_cnt != '0);
    accept     = bus.req_valid_i && bus.req_ready_o;
    last       = (idx == IW'(PAYLOAD_FLITS - 1));
    flit       = (state == HEAD) ? dest_q : pay_q[idx];
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = HEAD;
      HEAD:    if (send) state_next = BODY;
      BODY:    if (send && last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      credit_cnt  <= CW'(BUF_DEPTH);
      idx         <= '0;
      dest_q      <= '0;
      pay_q       <= '0;
      noc_valid_q <= 1'b0;
      noc_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        dest_q <= bus.req_dest_i;
        pay_q  <= bus.req_payload_i;
        idx    <= '0;
      end
      noc_valid_q <= send;
      if (send) begin
        noc_data_q <= flit;
        if (state == BODY) idx <= idx + IW'(1);
      end
      // A return that coincides with a send cancels out; a return into a
      // full counter is a router protocol error and is latched.
      case ({send, bus.noc_credit_i})
        2'b10: credit_cnt <= credit_cnt - CW'(1);
        2'b01: begin
          if (credit_cnt == CW'(BUF_DEPTH)) err_q <= 1'b1;
          else credit_cnt <= credit_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_local_inject_ni.sv
// Directed bench for local_inject_ni: a flit-queue/credit model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_local_inject_ni;
  localparam int unsigned PF  = 3;
  localparam int unsigned BUF = 8;

  logic clk;
  logic reset;

  local_inject_ni_if #(.PAYLOAD_FLITS(PF)) bus ();

  local_inject_ni #(.PAYLOAD_FLITS(PF), .BUF_DEPTH(BUF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a packet is simply a list of pending flits; one leaves per edge while credits remain.
  logic [15:0]         q[$];
  int                  m_cred = BUF;
  logic                m_err = 1'b0;
  logic                m_valid = 1'b0;
  logic [15:0]         m_data = '0;
  logic                m_idle, m_send;
  logic [16*PF-1:0]    m_pay;
  int                  cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      q.delete();
      m_cred  = BUF;
      m_err   = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
    end else begin
      m_idle = (q.size() == 0);
      m_send = (q.size() != 0) && (m_cred > 0);
      m_valid = m_send;
      if (m_send) m_data = q.pop_front();
      if (m_send && !bus.noc_credit_i) m_cred--;
      else if (!m_send && bus.noc_credit_i) begin
        if (m_cred == BUF) m_err = 1'b1;
        else m_cred++;
      end
      if (m_idle && bus.req_valid_i) begin
        q.push_back(bus.req_dest_i);
        m_pay = bus.req_payload_i;
        for (int i = 0; i < PF; i++) q.push_back(m_pay[16*i +: 16]);
      end
    end
  end

  logic [15:0] log_data[$];
  int          log_cyc[$];

  always @(negedge clk) begin
    chk("noc_valid", 32'(bus.noc_valid_o), 32'(m_valid));
    chk("noc_data", 32'(bus.noc_data_o), 32'(m_data));
    chk("req_ready", 32'(bus.req_ready_o), 32'(reset && (q.size() == 0)));
    chk("busy", 32'(bus.busy_o), 32'(reset && (q.size() != 0)));
    chk("credit_err", 32'(bus.credit_err_o), 32'(m_err));
    chk("credits", 32'(dut.credit_cnt), 32'(m_cred));
    if (bus.noc_valid_o === 1'b1) begin
      log_data.push_back(bus.noc_data_o);
      log_cyc.push_back(cyc);
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic wait_idle(input string name, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.req_ready_o === 1'b1) break;
    end
    chk({name, "_timeout"}, 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);
    #1;
  endtask

  int acc, c0;

  initial begin
    reset = 1'b0;
    bus.req_valid_i   = 1'b0;
    bus.req_dest_i    = '0;
    bus.req_payload_i = '0;
    bus.noc_credit_i  = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_cred", 32'(dut.credit_cnt), 32'd8);
    chk("rst_data", 32'(bus.noc_data_o), 32'h0000);
    do_reset();

    // Basic send
    bus.req_valid_i   = 1'b1;
    bus.req_dest_i    = 16'h0102;
    bus.req_payload_i = {16'h0C0C, 16'h0B0B, 16'h0A0A};
    @(negedge clk);
    acc = cyc;
    bus.req_valid_i = 1'b0;
    wait_idle("basic", 20);
    chk("basic_n", 32'(log_data.size()), 32'd4);
    if (log_data.size() == 4) begin
      chk("basic_f0", 32'(log_data[0]), 32'h0102);
      chk("basic_f1", 32'(log_data[1]), 32'h0A0A);
      chk("basic_f2", 32'(log_data[2]), 32'h0B0B);
      chk("basic_f3", 32'(log_data[3]), 32'h0C0C);
      for (int i = 0; i < 4; i++) chk("basic_lat", 32'(log_cyc[i] - acc), 32'(i + 1));
    end
    chk("basic_cred", 32'(dut.credit_cnt), 32'd4);
    chk("model_cred", 32'(m_cred), 32'd4);

    // Credit stall with back-to-back requests; payload changes mid-packet
    do_reset();
    bus.req_valid_i   = 1'b1;
    bus.req_dest_i    = 16'h0201;
    bus.req_payload_i = {16'h3333, 16'h2222, 16'h1111};
    @(negedge clk);
    bus.req_dest_i    = 16'h0403;
    bus.req_payload_i = {16'h6666, 16'h5555, 16'h4444};
    repeat (6) @(negedge clk);
    bus.req_dest_i    = 16'h0605;
    bus.req_payload_i = {16'h9999, 16'h8888, 16'h7777};
    repeat (6) @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("stall_n", 32'(log_data.size()), 32'd8);
    if (log_data.size() == 8) begin
      chk("stall_a1", 32'(log_data[1]), 32'h1111);
      chk("stall_a3", 32'(log_data[3]), 32'h3333);
      chk("stall_b0", 32'(log_data[4]), 32'h0403);
      chk("stall_b3", 32'(log_data[7]), 32'h6666);
    end
    chk("stall_cred", 32'(dut.credit_cnt), 32'd0);
    chk("stall_busy", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    c0 = cyc;
    bus.noc_credit_i = 1'b1;
    @(negedge clk);
    bus.noc_credit_i = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("resume_n", 32'(log_data.size()), 32'd9);
    if (log_data.size() == 9) begin
      chk("resume_flit", 32'(log_data[8]), 32'h0605);
      chk("resume_cyc", 32'(log_cyc[8] - c0), 32'd2);
    end
    chk("resume_cred", 32'(dut.credit_cnt), 32'd0);

    // Credit return on the same edge as a send
    do_reset();
    bus.req_valid_i   = 1'b1;
    bus.req_dest_i    = 16'h0304;
    bus.req_payload_i = {16'hCAFE, 16'hBEEF, 16'hF00D};
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    bus.noc_credit_i = 1'b1;
    @(negedge clk);
    bus.noc_credit_i = 1'b0;
    wait_idle("simul", 20);
    chk("simul_cred", 32'(dut.credit_cnt), 32'd5);
    chk("simul_n", 32'(log_data.size()), 32'd4);

    // Overflow from a full counter
    bus.noc_credit_i = 1'b1;
    repeat (4) @(negedge clk);
    bus.noc_credit_i = 1'b0;
    @(negedge clk);
    #1;
    chk("ovf_cred", 32'(dut.credit_cnt), 32'd8);
    chk("ovf_err", 32'(bus.credit_err_o), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("ovf_sticky", 32'(bus.credit_err_o), 32'd1);
    do_reset();
    #1;
    chk("ovf_clear", 32'(bus.credit_err_o), 32'd0);

    // Reset in the middle of a packet
    @(negedge clk);
    bus.req_valid_i   = 1'b1;
    bus.req_dest_i    = 16'h0A0B;
    bus.req_payload_i = {16'h0003, 16'h0002, 16'h0001};
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_head_v", 32'(bus.noc_valid_o), 32'd1);
    chk("mid_head_d", 32'(bus.noc_data_o), 32'h0A0B);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_valid", 32'(bus.noc_valid_o), 32'd0);
    chk("mid_ready", 32'(bus.req_ready_o), 32'd0);
    chk("mid_busy", 32'(bus.busy_o), 32'd0);
    chk("mid_cred", 32'(dut.credit_cnt), 32'd8);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_ready_rel", 32'(bus.req_ready_o), 32'd1);
    repeat (5) @(negedge clk);
    #1;
    chk("mid_no_more", 32'(log_data.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
